// File: rtl/multi_channel_pulser.sv
// rtl/multi_channel_pulser.sv - per-channel synchronise, debounce and edge-pulse generator
// Optional auto-repeat of rise_pulse: define MULTI_CHANNEL_PULSER_AUTO_REPEAT_EN
module multi_channel_pulser #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CW-1:0]       cnt [CHANNELS];
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] rep_fire;

    // A channel accepts its synchronised value once it has differed from level for DEBOUNCE_CYCLES edges
    always_comb begin
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = (s2[i] != level[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Synchroniser chain, debounce counters, level and edge pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            level      <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= raw_in;
            s2         <= s1;
            rise_pulse <= rep_fire;
            fall_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    level[i] <= s2[i];
                    cnt[i]   <= '0;
                    if (s2[i]) begin
                        rise_pulse[i] <= 1'b1;
                    end else begin
                        fall_pulse[i] <= 1'b1;
                    end
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef MULTI_CHANNEL_PULSER_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]       rcnt [CHANNELS];
    logic [CHANNELS-1:0] rep_phase;

    // Repeat fires when the held channel reaches its delay (first) or period (later) target;
    // suppressed on the edge where the channel falls so rise and fall never coincide
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rep_fire[i] = level[i] && !accept[i] &&
                          (rcnt[i] == (rep_phase[i] ? PER_LAST : DLY_LAST));
        end
    end

    // Repeat counters run only while the debounced level is high
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset || !level[i]) begin
                rcnt[i]      <= '0;
                rep_phase[i] <= 1'b0;
            end else if (rep_fire[i]) begin
                rcnt[i]      <= '0;
                rep_phase[i] <= 1'b1;
            end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    assign any_pulse = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_multi_channel_pulser.sv
// tb/tb_multi_channel_pulser.sv - directed self-checking bench for multi_channel_pulser
module tb_multi_channel_pulser;

    localparam int CH  = 4;
    localparam int D   = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] raw_in;
    logic [CH-1:0] level;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic          any_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int rise_cnt [CH];
    int fall_cnt [CH];
    int both_seen = 0;
    int any_bad   = 0;

    multi_channel_pulser #(
        .CHANNELS(CH),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .level(level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                if (rise_pulse[i]) rise_cnt[i]++;
                if (fall_pulse[i]) fall_cnt[i]++;
                if (rise_pulse[i] && fall_pulse[i]) both_seen++;
            end
            if (any_pulse !== (|rise_pulse || |fall_pulse)) any_bad++;
        end
    end

    initial begin
        int r0, f0, c, lh, ll;
        logic [1:0] exp_rf;
        reset  = 1'b1;
        raw_in = '0;
        repeat (3) tick();
        check("rst_level", 32'(level), 32'h0);
        check("rst_rise", 32'(rise_pulse), 32'h0);
        check("rst_fall", 32'(fall_pulse), 32'h0);
        check("rst_any", 32'(any_pulse), 32'h0);
        reset = 1'b0;
        repeat (D + 4) tick();
        check("idle_level", 32'(level), 32'h0);

        // 1: single rise on ch0, visible after edge k+1+D
        raw_in[0] = 1'b1;
        repeat (D + 1) tick();
        check("t1_level_early", 32'(level), 32'h0);
        check("t1_rise_early", 32'(rise_pulse), 32'h0);
        tick();
        check("t1_level", 32'(level), 32'h1);
        check("t1_rise", 32'(rise_pulse), 32'h1);
        check("t1_fall", 32'(fall_pulse), 32'h0);
        check("t1_any", 32'(any_pulse), 32'h1);
        tick();
        check("t1_rise_once", 32'(rise_pulse), 32'h0);
        check("t1_any_once", 32'(any_pulse), 32'h0);

        // 2: bounce train on ch1, every high run at most 3 cycles
        r0 = rise_cnt[1];
        f0 = fall_cnt[1];
        c  = 0;
        for (int i = 0; c < 50; i++) begin
            lh = (i % 3) + 1;
            ll = (i % 2) + 1;
            raw_in[1] = 1'b1;
            repeat (lh) tick();
            raw_in[1] = 1'b0;
            repeat (ll) tick();
            c += lh + ll;
        end
        repeat (D + 4) tick();
        check("t2_level", 32'(level[1]), 32'h0);
        check("t2_no_rise", 32'(rise_cnt[1] - r0), 32'h0);
        check("t2_no_fall", 32'(fall_cnt[1] - f0), 32'h0);

        // 3: ch2 press then release
        r0 = rise_cnt[2];
        f0 = fall_cnt[2];
        raw_in[2] = 1'b1;
        repeat (D + 1) tick();
        check("t3_rise_early", 32'(rise_pulse[2]), 32'h0);
        tick();
        check("t3_rise", 32'(rise_pulse[2]), 32'h1);
        check("t3_level_hi", 32'(level[2]), 32'h1);
        repeat (5) tick();
        raw_in[2] = 1'b0;
        repeat (D + 1) tick();
        check("t3_fall_early", 32'(fall_pulse[2]), 32'h0);
        check("t3_level_hold", 32'(level[2]), 32'h1);
        tick();
        check("t3_fall", 32'(fall_pulse[2]), 32'h1);
        check("t3_fall_no_rise", 32'(rise_pulse[2]), 32'h0);
        check("t3_level_lo", 32'(level[2]), 32'h0);
        tick();
        check("t3_fall_once", 32'(fall_pulse[2]), 32'h0);
        check("t3_rise_total", 32'(rise_cnt[2] - r0), 32'h1);
        check("t3_fall_total", 32'(fall_cnt[2] - f0), 32'h1);

        // 4: ch0 and ch3 rise on the same edge
        raw_in[0] = 1'b0;
        repeat (D + 4) tick();
        check("t4_all_low", 32'(level), 32'h0);
        raw_in[0] = 1'b1;
        raw_in[3] = 1'b1;
        repeat (D + 1) tick();
        check("t4_rise_early", 32'(rise_pulse), 32'h0);
        tick();
        check("t4_rise", 32'(rise_pulse), 32'h9);
        check("t4_any", 32'(any_pulse), 32'h1);
        check("t4_level", 32'(level), 32'h9);
        tick();
        check("t4_rise_once", 32'(rise_pulse), 32'h0);
        check("t4_any_once", 32'(any_pulse), 32'h0);

        // 5: one-cycle reset while ch0/ch3 high and raw held
        reset = 1'b1;
        tick();
        check("t5_level", 32'(level), 32'h0);
        check("t5_rise", 32'(rise_pulse), 32'h0);
        check("t5_fall", 32'(fall_pulse), 32'h0);
        check("t5_any", 32'(any_pulse), 32'h0);
        reset = 1'b0;
        repeat (D + 1) tick();
        check("t5_rise_early", 32'(rise_pulse), 32'h0);
        check("t5_level_early", 32'(level), 32'h0);
        tick();
        check("t5_rise_again", 32'(rise_pulse), 32'h9);
        check("t5_level_again", 32'(level), 32'h9);

        // 6: ch0 held past the first rise at P, released so the fall lands at P+56
        for (int j = 1; j <= 80; j++) begin
            if (j == 51) raw_in[0] = 1'b0;
            tick();
            exp_rf = 2'b00;
`ifdef MULTI_CHANNEL_PULSER_AUTO_REPEAT_EN
            if (j == RD || (j > RD && j <= 55 && ((j - RD) % RP) == 0)) exp_rf = 2'b10;
`endif
            if (j == 56) exp_rf = 2'b01;
            check($sformatf("t6_ch0_j%0d", j), 32'({rise_pulse[0], fall_pulse[0]}), 32'(exp_rf));
        end

        check("never_both", 32'(both_seen), 32'h0);
        check("any_is_or", 32'(any_bad), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
